// File: rtl/vga_timing_generator_pkg.sv
// rtl/vga_timing_generator_pkg.sv - shared VGA phase enum, default timing constants, phase helper
//
// Contents:
//   axis_phase_e   phase of one scan axis: VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE
//   DEF_*          default 640x480@60 timing (800 x 525 totals, sync bounds)
//   phase_of()     maps an axis count onto its phase given the region widths
package vga_timing_generator_pkg;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } axis_phase_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL       = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL       = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HSYNC_START   = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HSYNC_END     = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START   = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VSYNC_END     = DEF_VSYNC_START + DEF_V_SYNC;

    function automatic axis_phase_e phase_of(
        input logic [31:0] count,
        input logic [31:0] visible_len,
        input logic [31:0] front_len,
        input logic [31:0] sync_len
    );
        if (count < visible_len)
            return VISIBLE;
        else if (count < visible_len + front_len)
            return FRONT;
        else if (count < visible_len + front_len + sync_len)
            return SYNC;
        else
            return BACK;
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// rtl/vga_timing_generator_if.sv - video timing output bundle
//
// Signals:
//   column, row      current scan position
//   display_enable   position lies inside the visible area
//   hsync, vsync     active-low syncs, one cycle behind the position
//   vblank_tick      one-cycle pulse on the first cycle of vertical blank
//   frame_count      completed frames, wrapping at 16 bits
// Modports: master drives the bundle (timing generator), slave consumes it.
interface vga_timing_generator_if;

    logic [31:0] column;
    logic [31:0] row;
    logic        display_enable;
    logic        hsync;
    logic        vsync;
    logic        vblank_tick;
    logic [15:0] frame_count;

    modport master (
        output column,
        output row,
        output display_enable,
        output hsync,
        output vsync,
        output vblank_tick,
        output frame_count
    );

    modport slave (
        input column,
        input row,
        input display_enable,
        input hsync,
        input vsync,
        input vblank_tick,
        input frame_count
    );

endinterface

// File: rtl/vga_timing_generator_axis_counter.sv
// rtl/vga_timing_generator_axis_counter.sv - wrapping scan-axis counter with phase and wrap pulse
//
// Ports:
//   vga_clock    pixel clock, rising edge
//   reset        asynchronous active-low reset
//   advance      step the count this cycle
//   count        registered position, 0 .. TOTAL-1
//   phase        registered phase matching count
//   next_count   value count takes at the next edge
//   next_phase   phase matching next_count
//   wrap         high when this cycle's step takes count from TOTAL-1 back to 0
module vga_axis_counter
    import vga_timing_generator_pkg::*;
#(
    parameter int VISIBLE_LEN = DEF_H_VISIBLE,
    parameter int FRONT_LEN   = DEF_H_FRONT,
    parameter int SYNC_LEN    = DEF_H_SYNC,
    parameter int BACK_LEN    = DEF_H_BACK
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        advance,
    output logic [31:0] count,
    output axis_phase_e phase,
    output logic [31:0] next_count,
    output axis_phase_e next_phase,
    output logic        wrap
);

    localparam logic [31:0] TOTAL = 32'(VISIBLE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN);

    assign wrap = advance && (count == TOTAL - 32'd1);

    always_comb begin
        next_count = count;
        if (advance)
            next_count = wrap ? 32'd0 : count + 32'd1;
    end

    assign next_phase = phase_of(next_count, 32'(VISIBLE_LEN), 32'(FRONT_LEN), 32'(SYNC_LEN));

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
            phase <= VISIBLE;
        end else begin
            count <= next_count;
            phase <= next_phase;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - VGA raster timing: position, display enable, syncs, vblank tick, frame count
//
// Ports:
//   vga_clock   pixel clock, all logic on its rising edge
//   reset       asynchronous active-low reset
//   video       master side of vga_timing_generator_if (column, row, display_enable,
//               hsync, vsync, vblank_tick, frame_count)
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    vga_timing_generator_if.master video
);

    // The first edge after reset release only primes the registered outputs
    // for position (0,0); counting starts on the edge after that, so the
    // first presented cycle is (0,0) with display_enable already valid.
    logic        running;

    logic [31:0] h_count, h_next_count;
    logic [31:0] v_count, v_next_count;
    axis_phase_e h_phase, h_next_phase;
    axis_phase_e v_phase, v_next_phase;
    logic        h_wrap, v_wrap;

    logic        display_enable_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        vblank_tick_q;
    logic [15:0] frame_count_q;

    vga_axis_counter #(
        .VISIBLE_LEN (H_VISIBLE),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK)
    ) u_h_axis (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .advance    (running),
        .count      (h_count),
        .phase      (h_phase),
        .next_count (h_next_count),
        .next_phase (h_next_phase),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE_LEN (V_VISIBLE),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK)
    ) u_v_axis (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .advance    (h_wrap),
        .count      (v_count),
        .phase      (v_phase),
        .next_count (v_next_count),
        .next_phase (v_next_phase),
        .wrap       (v_wrap)
    );

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            running          <= 1'b0;
            display_enable_q <= 1'b0;
            hsync_q          <= 1'b1;
            vsync_q          <= 1'b1;
            vblank_tick_q    <= 1'b0;
            frame_count_q    <= 16'd0;
        end else begin
            running          <= 1'b1;
            // Enable and vblank are built from the upcoming position so they
            // line up with the column/row registered on the same edge.
            display_enable_q <= (h_next_phase == VISIBLE) && (v_next_phase == VISIBLE);
            vblank_tick_q    <= (v_next_count == 32'(V_VISIBLE)) && (h_next_count == 32'd0);
            // Syncs come from the current phase, giving the one-cycle lag
            // that matches the downstream colour register.
            hsync_q          <= (h_phase != SYNC);
            vsync_q          <= (v_phase != SYNC);
            if (v_wrap)
                frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign video.column         = h_count;
    assign video.row            = v_count;
    assign video.display_enable = display_enable_q;
    assign video.hsync          = hsync_q;
    assign video.vsync          = vsync_q;
    assign video.vblank_tick    = vblank_tick_q;
    assign video.frame_count    = frame_count_q;

endmodule
